// File: rtl/m_alu_evtctl.sv
// Event controller downstream of the ALU: carry flag capture, mtime-increment
// request/ack/service sequencing with miss counting, and sticky minstret overflow.
module m_alu_evtctl #(
   parameter int MTIMETAP     = 0,
   parameter int SRAMADRWIDTH = 0,
   parameter int MISSW        = 4
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             alu_carryout,
   input  logic             alu_tapout,
   input  logic             alu_minstretofl,
   input  logic             cy_we,
   input  logic             irq_en,
   input  logic             ack_mtimeinc,
   input  logic             svc_done,
   input  logic             ack_minstret,
   input  logic             clr_missed,
   output logic             cyflag,
   output logic             irq_mtimeinc,
   output logic             in_service,
   output logic             irq_minstret,
   output logic [MISSW-1:0] missed,
   output logic             overrun
);

   // Carry flag register
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cyflag <= 1'b0;
      end else if (cy_we) begin
         cyflag <= alu_carryout;
      end else begin
         cyflag <= cyflag;
      end
   end

   if (MTIMETAP > 13) begin : g_mtime
      typedef enum logic [1:0] {
         IDLE = 2'd0,
         PEND = 2'd1,
         SVC  = 2'd2
      } state_t;

      state_t           state;
      state_t           state_nx;
      logic             requeue;
      logic             requeue_nx;
      logic             miss_inc;
      logic [MISSW-1:0] miss_max;

      assign miss_max = {MISSW{1'b1}};

      // State and requeue registers
      always_ff @(posedge CLK_I) begin
         if (RST_I) begin
            state   <= IDLE;
            requeue <= 1'b0;
         end else begin
            state   <= state_nx;
            requeue <= requeue_nx;
         end
      end

      // Next-state logic; a tap that cannot be queued anywhere counts as a miss
      always_comb begin
         state_nx   = state;
         requeue_nx = requeue;
         miss_inc   = 1'b0;
         case (state)
            IDLE: begin
               if (alu_tapout) begin
                  state_nx = PEND;
               end else begin
                  state_nx = IDLE;
               end
            end
            PEND: begin
               if (ack_mtimeinc) begin
                  state_nx   = SVC;
                  requeue_nx = alu_tapout;
               end else if (alu_tapout) begin
                  miss_inc = 1'b1;
               end else begin
                  state_nx = PEND;
               end
            end
            SVC: begin
               miss_inc = alu_tapout & requeue;
               if (svc_done) begin
                  state_nx   = (requeue | alu_tapout) ? PEND : IDLE;
                  requeue_nx = 1'b0;
               end else if (alu_tapout) begin
                  requeue_nx = 1'b1;
               end else begin
                  requeue_nx = requeue;
               end
            end
            default: begin
               state_nx   = IDLE;
               requeue_nx = 1'b0;
            end
         endcase
      end

      // Saturating miss counter; clear has priority over an increment
      always_ff @(posedge CLK_I) begin
         if (RST_I) begin
            missed  <= {MISSW{1'b0}};
            overrun <= 1'b0;
         end else if (clr_missed) begin
            missed  <= {MISSW{1'b0}};
            overrun <= 1'b0;
         end else if (miss_inc) begin
            if (missed == miss_max) begin
               overrun <= 1'b1;
            end else begin
               missed <= missed + {{(MISSW-1){1'b0}}, 1'b1};
            end
         end else begin
            missed  <= missed;
            overrun <= overrun;
         end
      end

      assign irq_mtimeinc = (state == PEND) & irq_en;
      assign in_service   = (state == SVC);
   end else begin : g_no_mtime
      logic unused_mtime;
      assign unused_mtime = ^{alu_tapout, irq_en, ack_mtimeinc, svc_done, clr_missed};
      assign irq_mtimeinc = 1'b0;
      assign in_service   = 1'b0;
      assign missed       = {MISSW{1'b0}};
      assign overrun      = 1'b0;
   end

   if ((SRAMADRWIDTH != 0) && (MTIMETAP > 13)) begin : g_minstret
      // Sticky overflow pending bit; a new overflow beats a same-cycle ack
      always_ff @(posedge CLK_I) begin
         if (RST_I) begin
            irq_minstret <= 1'b0;
         end else if (alu_minstretofl) begin
            irq_minstret <= 1'b1;
         end else if (ack_minstret) begin
            irq_minstret <= 1'b0;
         end else begin
            irq_minstret <= irq_minstret;
         end
      end
   end else begin : g_no_minstret
      logic unused_minstret;
      assign unused_minstret = ^{alu_minstretofl, ack_minstret};
      assign irq_minstret    = 1'b0;
   end

endmodule

// File: tb/tb_m_alu_evtctl.sv
// Bench for m_alu_evtctl: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with default parameters checks tie-offs.
module tb_m_alu_evtctl;

   localparam int MW   = 2;
   localparam int MAXM = (1 << MW) - 1;

   logic clk = 1'b0;
   logic rst, carry, tap, ofl, cy_we, irq_en, ack, done, ack_mi, clr;

   logic          d_cy, d_irq, d_svc, d_mi, d_ovr;
   logic [MW-1:0] d_missed;
   logic          t_cy, t_irq, t_svc, t_mi, t_ovr;
   logic [3:0]    t_missed;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   bit m_cy, m_pend, m_busy, m_req, m_mi, m_ovr;
   int m_missed;

   always #5 clk = ~clk;

   m_alu_evtctl #(.MTIMETAP(20), .SRAMADRWIDTH(8), .MISSW(MW)) u_dut (
      .CLK_I(clk), .RST_I(rst), .alu_carryout(carry), .alu_tapout(tap),
      .alu_minstretofl(ofl), .cy_we(cy_we), .irq_en(irq_en),
      .ack_mtimeinc(ack), .svc_done(done), .ack_minstret(ack_mi),
      .clr_missed(clr), .cyflag(d_cy), .irq_mtimeinc(d_irq),
      .in_service(d_svc), .irq_minstret(d_mi), .missed(d_missed),
      .overrun(d_ovr)
   );

   m_alu_evtctl u_tie (
      .CLK_I(clk), .RST_I(rst), .alu_carryout(carry), .alu_tapout(tap),
      .alu_minstretofl(ofl), .cy_we(cy_we), .irq_en(irq_en),
      .ack_mtimeinc(ack), .svc_done(done), .ack_minstret(ack_mi),
      .clr_missed(clr), .cyflag(t_cy), .irq_mtimeinc(t_irq),
      .in_service(t_svc), .irq_minstret(t_mi), .missed(t_missed),
      .overrun(t_ovr)
   );

   function automatic logic [6:0] obs();
      return {d_cy, d_irq, d_svc, d_mi, d_missed, d_ovr};
   endfunction

   function automatic logic [6:0] expv();
      logic [MW-1:0] mm;
      mm = m_missed[MW-1:0];
      return {m_cy, m_pend & irq_en, m_busy, m_mi, mm, m_ovr};
   endfunction

   // advance the model with the inputs present before the edge
   task automatic model_step();
      bit attempt;
      attempt = 1'b0;
      if (rst) begin
         m_cy = 0; m_pend = 0; m_busy = 0; m_req = 0; m_mi = 0;
         m_ovr = 0; m_missed = 0;
      end else begin
         if (cy_we) m_cy = carry;
         if (ofl) m_mi = 1'b1;
         else if (ack_mi) m_mi = 1'b0;
         if (m_pend) begin
            if (ack) begin
               m_pend = 0; m_busy = 1; m_req = tap;
            end else if (tap) begin
               attempt = 1'b1;
            end
         end else if (m_busy) begin
            if (tap && m_req) attempt = 1'b1;
            if (done) begin
               m_busy = 0; m_pend = m_req || tap; m_req = 0;
            end else if (tap) begin
               m_req = 1;
            end
         end else if (tap) begin
            m_pend = 1;
         end
         if (clr) begin
            m_missed = 0; m_ovr = 0;
         end else if (attempt) begin
            if (m_missed == MAXM) m_ovr = 1;
            else m_missed = m_missed + 1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      rst = 0; tap = 0; ofl = 0; cy_we = 0; ack = 0; done = 0;
      ack_mi = 0; clr = 0; carry = 0;
   endtask

   task automatic test_reset();
      irq_en = 1; rst = 1; tick();
      if (obs() !== 7'b0) $display("FAIL reset: got %b want %b", obs(), 7'b0);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_carry();
      cy_we = 1; carry = 1; tick();
      if (d_cy !== 1'b1) $display("FAIL carry_capture: got %b want 1", d_cy);
      else n_pass++;
      n_checks++;
      cy_we = 0; carry = 0; tick();
      if (d_cy !== 1'b1) $display("FAIL carry_hold: got %b want 1", d_cy);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_handshake();
      tap = 1; tick();
      if ({d_irq, d_svc} !== 2'b10) $display("FAIL hs_request: got %b want 10", {d_irq, d_svc});
      else n_pass++;
      n_checks++;
      irq_en = 0; #1;
      if (d_irq !== 1'b0) $display("FAIL hs_irq_gate: got %b want 0", d_irq);
      else n_pass++;
      n_checks++;
      tick(); irq_en = 1; #1;
      if (d_irq !== 1'b1) $display("FAIL hs_still_pend: got %b want 1", d_irq);
      else n_pass++;
      n_checks++;
      ack = 1; tick();
      if ({d_irq, d_svc} !== 2'b01) $display("FAIL hs_service: got %b want 01", {d_irq, d_svc});
      else n_pass++;
      n_checks++;
      tick(); done = 1; tick();
      if (obs() !== 7'b1000000) $display("FAIL hs_idle: got %b want %b", obs(), 7'b1000000);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_requeue();
      tap = 1; tick();
      tap = 1; ack = 1; tick();
      if ({d_svc, d_missed} !== {1'b1, 2'd0}) $display("FAIL rq_tap_ack: got %b want 100", {d_svc, d_missed});
      else n_pass++;
      n_checks++;
      done = 1; tick();
      if ({d_irq, d_svc} !== 2'b10) $display("FAIL rq_repend: got %b want 10", {d_irq, d_svc});
      else n_pass++;
      n_checks++;
      ack = 1; tick();
      tap = 1; done = 1; tick();
      if ({d_irq, d_svc, d_missed} !== 4'b1000) $display("FAIL rq_tap_done: got %b want 1000", {d_irq, d_svc, d_missed});
      else n_pass++;
      n_checks++;
      ack = 1; tick(); done = 1; tick();
   endtask

   task automatic test_miss_saturation();
      tap = 1; tick();
      for (int i = 0; i < 4; i++) begin
         tap = 1; tick();
      end
      if ({d_missed, d_ovr} !== 3'b111) $display("FAIL miss_sat: got %b want 111", {d_missed, d_ovr});
      else n_pass++;
      n_checks++;
      clr = 1; tap = 1; tick();
      if ({d_irq, d_missed, d_ovr} !== 4'b1000) $display("FAIL miss_clr: got %b want 1000", {d_irq, d_missed, d_ovr});
      else n_pass++;
      n_checks++;
      rst = 1; tick();
   endtask

   task automatic test_minstret();
      ofl = 1; ack_mi = 1; tick();
      if (d_mi !== 1'b1) $display("FAIL mi_set_wins: got %b want 1", d_mi);
      else n_pass++;
      n_checks++;
      tick();
      if (d_mi !== 1'b1) $display("FAIL mi_sticky: got %b want 1", d_mi);
      else n_pass++;
      n_checks++;
      ack_mi = 1; tick();
      if (d_mi !== 1'b0) $display("FAIL mi_ack: got %b want 0", d_mi);
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_reset_mid_svc();
      cy_we = 1; carry = 1; ofl = 1; tap = 1; tick();
      tap = 1; ack = 1; tick();
      rst = 1; tap = 1; done = 1; cy_we = 1; carry = 1; ofl = 1; tick();
      if (obs() !== 7'b0) $display("FAIL rst_svc_outputs: got %b want %b", obs(), 7'b0);
      else n_pass++;
      n_checks++;
      tap = 1; tick(); ack = 1; tick(); done = 1; tick();
      if ({d_irq, d_svc} !== 2'b00) $display("FAIL rst_svc_requeue: got %b want 00", {d_irq, d_svc});
      else n_pass++;
      n_checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 49) == 0);
         tap    = ($urandom_range(0, 2) == 0);
         ack    = ($urandom_range(0, 2) == 0);
         done   = ($urandom_range(0, 2) == 0);
         clr    = ($urandom_range(0, 9) == 0);
         ofl    = ($urandom_range(0, 5) == 0);
         ack_mi = ($urandom_range(0, 3) == 0);
         cy_we  = $urandom_range(0, 1);
         carry  = $urandom_range(0, 1);
         tick();
         irq_en = $urandom_range(0, 1);
         #1;
         if (obs() !== expv()) $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
         else n_pass++;
         n_checks++;
         if ({t_cy, t_irq, t_svc, t_mi, t_missed, t_ovr} !== {m_cy, 8'b0})
            $display("FAIL tieoff[%0d]: got %b want %b", i, {t_cy, t_irq, t_svc, t_mi, t_missed, t_ovr}, {m_cy, 8'b0});
         else n_pass++;
         n_checks++;
      end
   endtask

   initial begin
      rst = 1; tap = 0; ofl = 0; cy_we = 0; ack = 0; done = 0;
      ack_mi = 0; clr = 0; carry = 0; irq_en = 1;
      #2;
      test_reset();
      test_carry();
      test_handshake();
      test_requeue();
      test_miss_saturation();
      test_minstret();
      test_reset_mid_svc();
      rst = 1; tick();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
